// File: rtl/gate_bist_pkg.sv
// Shared types, default taps and the Galois step function for the gate-model BIST.
package gate_bist_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [MAX_W-1:0] DEF_LFSR_TAPS = 64'h2C03;
  localparam logic [MAX_W-1:0] DEF_MISR_TAPS = 64'h240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One Galois shift: value must be zero-extended; the caller truncates to its width.
  function automatic logic [MAX_W-1:0] galois_next(input logic [MAX_W-1:0] value,
                                                   input logic [MAX_W-1:0] taps,
                                                   input logic [MAX_W-1:0] inject);
    return (value >> 1) ^ (value[0] ? taps : '0) ^ inject;
  endfunction

endpackage

// File: rtl/gate_model_bist_if.sv
// Control, pattern and response bundle between a BIST harness and its controller/core.
interface gate_model_bist_if #(
  parameter int unsigned IN_W  = 14,
  parameter int unsigned OUT_W = 10,
  parameter int unsigned CNT_W = 9
);
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  seed;
  logic [OUT_W-1:0] golden;
  logic [IN_W-1:0]  pat;
  logic [OUT_W-1:0] resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] signature;
  logic [CNT_W-1:0] pat_cnt;

  modport master (
    output start, abort, seed, golden, resp,
    input  pat, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, abort, seed, golden, resp,
    output pat, busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/gate_bist_galois.sv
// Galois shift register with synchronous parallel load and per-step parallel inject.
module gate_bist_galois
  import gate_bist_pkg::*;
#(
  parameter int unsigned     W    = 4,
  parameter logic [W-1:0]    TAPS = W'(4'hC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] inject,
  output logic [W-1:0] q
);

  logic [W-1:0] nxt_c;

  // Next value for one shift with the current inject word folded in.
  assign nxt_c = W'(galois_next(MAX_W'(q), MAX_W'(TAPS), MAX_W'(inject)));

  // Load has priority over stepping; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= nxt_c;
    end
  end

endmodule

// File: rtl/gate_model_bist.sv
// BIST harness: LFSR patterns into a combinational core, MISR compaction, golden compare.
// Optional build macro BIST_RESP_PIPE_EN registers resp before the MISR and adds a DRAIN state.
module gate_model_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned        IN_W      = 14,
  parameter int unsigned        OUT_W     = 10,
  parameter int unsigned        NUM_PAT   = 256,
  parameter logic [IN_W-1:0]    LFSR_TAPS = IN_W'(DEF_LFSR_TAPS),
  parameter logic [OUT_W-1:0]   MISR_TAPS = OUT_W'(DEF_MISR_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_model_bist_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NUM_PAT + 1);

  state_t           state;
  state_t           state_nxt;
  logic             start_load;
  logic             step;
  logic             misr_en;
  logic             busy_q, done_q, pass_q;
  logic             busy_d, done_d, pass_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_pat;
  logic [IN_W-1:0]  seed_safe;
  logic [OUT_W-1:0] misr_q;
  logic [OUT_W-1:0] misr_in;
  logic [OUT_W-1:0] misr_nxt;

`ifdef BIST_RESP_PIPE_EN
  logic [OUT_W-1:0] resp_q;
  logic             valid_q;

  // Response pipeline stage; valid marks a response captured from a RUN pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      resp_q  <= bus.resp;
      valid_q <= step;
    end
  end

  assign misr_in = resp_q;
`else
  assign misr_in = bus.resp;
`endif

  // A zero seed would lock the LFSR, so substitute all-ones.
  assign seed_safe = (bus.seed == '0) ? {IN_W{1'b1}} : bus.seed;
  assign last_pat  = (cnt_q == CNT_W'(NUM_PAT - 1));
  assign misr_nxt  = OUT_W'(galois_next(MAX_W'(misr_q), MAX_W'(MISR_TAPS), MAX_W'(misr_in)));

  gate_bist_galois #(.W(IN_W), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_load),
    .load_val (seed_safe),
    .en       (step),
    .inject   ('0),
    .q        (bus.pat)
  );

  gate_bist_galois #(.W(OUT_W), .TAPS(MISR_TAPS)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_load),
    .load_val ('0),
    .en       (misr_en),
    .inject   (misr_in),
    .q        (misr_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath strobes and next status flags; abort overrides everything.
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    step       = 1'b0;
    misr_en    = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    if (bus.abort) begin
      state_nxt = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state_nxt  = RUN;
            start_load = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            pass_d     = 1'b0;
          end
        end
        RUN: begin
          step = 1'b1;
`ifdef BIST_RESP_PIPE_EN
          misr_en = valid_q;
          if (last_pat) begin
            state_nxt = DRAIN;
          end
`else
          misr_en = 1'b1;
          if (last_pat) begin
            state_nxt = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (misr_nxt == bus.golden);
          end
`endif
        end
`ifdef BIST_RESP_PIPE_EN
        DRAIN: begin
          misr_en   = valid_q;
          state_nxt = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (misr_nxt == bus.golden);
        end
`endif
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  // Pattern counter: cleared on start, saturates at NUM_PAT, held on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_load) begin
      cnt_q <= '0;
    end else if (step && (cnt_q < CNT_W'(NUM_PAT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;
  assign bus.pat_cnt   = cnt_q;

endmodule

// File: tb/tb_gate_model_bist.sv
// Directed bench for gate_model_bist with 4-bit LFSR/MISR and taps 4'hC.
module tb_gate_model_bist;

`ifdef BIST_RESP_PIPE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [3:0] exp_seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                               4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  gate_model_bist_if #(.IN_W(4), .OUT_W(4), .CNT_W(4)) b15 ();
  gate_model_bist_if #(.IN_W(4), .OUT_W(4), .CNT_W(3)) b4 ();

  gate_model_bist #(.IN_W(4), .OUT_W(4), .NUM_PAT(15),
                    .LFSR_TAPS(4'hC), .MISR_TAPS(4'hC)) dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b15.slave)
  );

  gate_model_bist #(.IN_W(4), .OUT_W(4), .NUM_PAT(4),
                    .LFSR_TAPS(4'hC), .MISR_TAPS(4'hC)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  assign b15.resp = b15.pat ^ 4'h5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    b15.start  = 1'b0;
    b15.abort  = 1'b0;
    b15.seed   = 4'h0;
    b15.golden = 4'h0;
    b4.start   = 1'b0;
    b4.abort   = 1'b0;
    b4.seed    = 4'h1;
    b4.golden  = 4'h8;
    b4.resp    = 4'h1;
    #2;

    // Reset state
    chk("rst_pat",  64'(b4.pat),       64'h0);
    chk("rst_busy", 64'(b4.busy),      64'h0);
    chk("rst_done", 64'(b4.done),      64'h0);
    chk("rst_pass", 64'(b4.pass),      64'h0);
    chk("rst_sig",  64'(b4.signature), 64'h0);
    chk("rst_cnt",  64'(b4.pat_cnt),   64'h0);
    chk("rst_pat15", 64'(b15.pat),     64'h0);

    #10;
    rst_n = 1'b1;
    tick();
    tick();

    // Sequence from seed 1 over 15 patterns
    b15.seed  = 4'h1;
    b15.start = 1'b1;
    tick();
    b15.start = 1'b0;
    chk("seq_busy", 64'(b15.busy), 64'h1);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("seq_pat%0d", k), 64'(b15.pat), 64'(exp_seq[k]));
      chk($sformatf("seq_nodone%0d", k), 64'(b15.done), 64'h0);
      tick();
    end
    repeat (LAT) tick();
    chk("seq_done", 64'(b15.done),    64'h1);
    chk("seq_busy0", 64'(b15.busy),   64'h0);
    chk("seq_cnt",  64'(b15.pat_cnt), 64'd15);
    tick();
    tick();
    chk("seq_hold_pat",  64'(b15.pat),  64'h1);
    chk("seq_hold_done", 64'(b15.done), 64'h1);

    // Zero seed restarted directly from DONE
    b15.seed  = 4'h0;
    b15.start = 1'b1;
    tick();
    b15.start = 1'b0;
    chk("zs_done_clr", 64'(b15.done), 64'h0);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("zs_pat%0d", k), 64'(b15.pat), 64'(exp_seq[(9 + k) % 15]));
      tick();
    end
    repeat (LAT) tick();
    chk("zs_done", 64'(b15.done), 64'h1);

    // Signature with resp tied to 1, golden 8
    b4.golden = 4'h8;
    b4.start  = 1'b1;
    tick();
    b4.start = 1'b0;
    repeat (3 + LAT) tick();
    chk("sig_early_done", 64'(b4.done), 64'h0);
    tick();
    chk("sig_done", 64'(b4.done),      64'h1);
    chk("sig_val",  64'(b4.signature), 64'h8);
    chk("sig_pass", 64'(b4.pass),      64'h1);
    chk("sig_cnt",  64'(b4.pat_cnt),   64'd4);
    chk("sig_busy", 64'(b4.busy),      64'h0);

    // Wrong golden fails
    b4.golden = 4'h9;
    b4.start  = 1'b1;
    tick();
    b4.start = 1'b0;
    repeat (4 + LAT) tick();
    chk("bad_done", 64'(b4.done),      64'h1);
    chk("bad_sig",  64'(b4.signature), 64'h8);
    chk("bad_pass", 64'(b4.pass),      64'h0);

    // Abort at RUN cycle 2, then clean rerun
    b4.golden = 4'h8;
    b4.start  = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    tick();
    b4.abort = 1'b1;
    tick();
    b4.abort = 1'b0;
    chk("ab_busy", 64'(b4.busy),    64'h0);
    chk("ab_done", 64'(b4.done),    64'h0);
    chk("ab_pass", 64'(b4.pass),    64'h0);
    chk("ab_cnt",  64'(b4.pat_cnt), 64'd2);
    tick();
    chk("ab_idle_busy", 64'(b4.busy), 64'h0);
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    repeat (4 + LAT) tick();
    chk("rerun_done", 64'(b4.done),      64'h1);
    chk("rerun_sig",  64'(b4.signature), 64'h8);
    chk("rerun_pass", 64'(b4.pass),      64'h1);

    // Asynchronous reset at RUN cycle 3
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy", 64'(b4.busy), 64'h1);
    chk("mid_pat",  64'(b4.pat),  64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pat",  64'(b4.pat),       64'h0);
    chk("ar_busy", 64'(b4.busy),      64'h0);
    chk("ar_done", 64'(b4.done),      64'h0);
    chk("ar_pass", 64'(b4.pass),      64'h0);
    chk("ar_sig",  64'(b4.signature), 64'h0);
    chk("ar_cnt",  64'(b4.pat_cnt),   64'h0);
    chk("ar_done15", 64'(b15.done),   64'h0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
